// File: rtl/pfb_arb_pkg.sv
// Shared types, defaults and the round-robin pick function used by the
// multichannel PFB arbitration stages.
package pfb_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam int DEF_N_CH  = 4;
    localparam int DEF_DW    = 32;
    localparam int RR_MAX_CH = 16;

    // First set bit of req searching upward from last+1, wrapping modulo n_ch
    // (n_ch is a power of two). Returns last when nothing is requesting.
    function automatic logic [3:0] rr_pick(input logic [RR_MAX_CH-1:0] req,
                                           input logic [3:0]           last,
                                           input int                   n_ch);
        logic [3:0] cand;
        logic       found;
        rr_pick = last;
        found   = 1'b0;
        for (int off = 1; off <= RR_MAX_CH; off++) begin
            cand = 4'((int'(last) + off) & (n_ch - 1));
            if (off <= n_ch && !found && req[cand]) begin
                rr_pick = cand;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/pfb_output_arbiter_if.sv
// Stream bundle between the per-channel PFB outputs and the merged output.
// master = arbiter side, slave = environment (channel sources + downstream sink).
interface pfb_output_arbiter_if #(
    parameter int N_CH = 4,
    parameter int DW   = 32
);
    localparam int TW = $clog2(N_CH);

    // AXI-Stream handshake: a beat transfers on a rising clock edge where
    // tvalid and tready are both high; a source holds tdata/tlast stable from
    // raising tvalid until that beat, and tvalid never waits on tready.
    logic [N_CH*DW-1:0] s_tdata;
    logic [N_CH-1:0]    s_tvalid;
    logic [N_CH-1:0]    s_tlast;
    logic [N_CH-1:0]    s_tready;
    logic [DW-1:0]      m_tdata;
    logic               m_tvalid;
    logic               m_tlast;
    logic [TW-1:0]      m_tdest;
    logic               m_tready;

    modport master (
        input  s_tdata, s_tvalid, s_tlast, m_tready,
        output s_tready, m_tdata, m_tvalid, m_tlast, m_tdest
    );

    modport slave (
        output s_tdata, s_tvalid, s_tlast, m_tready,
        input  s_tready, m_tdata, m_tvalid, m_tlast, m_tdest
    );

endinterface

// File: rtl/pfb_rr_arbiter.sv
// Combinational round-robin picker: next requester after `last`, plus an
// any-request flag. Shared by the multichannel PFB stages.
module pfb_rr_arbiter
    import pfb_arb_pkg::*;
#(
    parameter int N_CH = DEF_N_CH
) (
    input  logic [N_CH-1:0]         req,
    input  logic [$clog2(N_CH)-1:0] last,
    output logic [$clog2(N_CH)-1:0] idx,
    output logic                    any
);
    localparam int IW = $clog2(N_CH);

    always_comb begin
        idx = IW'(rr_pick(RR_MAX_CH'(req), 4'(last), N_CH));
        any = |req;
    end

endmodule

// File: rtl/pfb_output_arbiter.sv
// Packet-level round-robin merge of the PFB channel streams onto one AXIS port.
// Define PFB_ARB_STALL_MON_EN to build the output stall monitor behind `block`.
module pfb_output_arbiter
    import pfb_arb_pkg::*;
#(
    parameter int N_CH        = DEF_N_CH,
    parameter int DW          = DEF_DW,
    parameter int MAX_BEATS   = 1024,
    parameter int STALL_LIMIT = 4096
) (
    input  logic                  clock,
    input  logic                  reset,
    pfb_output_arbiter_if.master  bus,
    input  logic [N_CH-1:0]       chan_en,
    output logic                  len_err,
    output logic                  block,
    output arb_state_t            state_dbg
);
    localparam int IW = $clog2(N_CH);
    localparam int CW = $clog2(MAX_BEATS) + 1;

    arb_state_t     state_q, state_d;
    logic [IW-1:0]  grant_q, grant_d;
    logic [IW-1:0]  last_q, last_d;
    logic [CW-1:0]  beat_cnt_q, beat_cnt_d;
    logic           len_err_q, len_err_d;

    logic [N_CH-1:0] req;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;

    logic            out_valid;
    logic            out_last;
    logic [DW-1:0]   out_data;
    logic            beat;
    logic [CW-1:0]   beat_num;

    assign req = bus.s_tvalid & chan_en;

    pfb_rr_arbiter #(.N_CH(N_CH)) u_pick (
        .req  (req),
        .last (last_q),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Datapath is a pure mux of the granted channel; nothing is buffered.
    always_comb begin
        out_valid    = 1'b0;
        out_last     = 1'b0;
        out_data     = '0;
        bus.s_tready = '0;
        if (state_q == ARB_GRANT) begin
            out_valid              = bus.s_tvalid[grant_q];
            out_last               = bus.s_tlast[grant_q];
            out_data               = bus.s_tdata[grant_q*DW +: DW];
            bus.s_tready[grant_q]  = bus.m_tready;
        end
    end

    assign bus.m_tvalid = out_valid;
    assign bus.m_tlast  = out_last;
    assign bus.m_tdata  = out_data;
    assign bus.m_tdest  = (state_q == ARB_GRANT) ? grant_q : '0;

    assign beat     = out_valid & bus.m_tready;
    assign beat_num = beat_cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        beat_cnt_d = beat_cnt_q;
        len_err_d  = len_err_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d    = ARB_GRANT;
                    grant_d    = pick_idx;
                    beat_cnt_d = '0;
                end
            end
            ARB_GRANT: begin
                if (beat) begin
                    // Saturate so an overlong packet cannot wrap and re-flag.
                    if (beat_cnt_q != CW'(MAX_BEATS)) beat_cnt_d = beat_num;
                    if (beat_num == CW'(MAX_BEATS) && !out_last) len_err_d = 1'b1;
                    if (out_last) begin
                        state_d = ARB_IDLE;
                        last_d  = grant_q;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            last_q     <= IW'(N_CH - 1);
            beat_cnt_q <= '0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            beat_cnt_q <= beat_cnt_d;
            len_err_q  <= len_err_d;
        end
    end

    assign len_err   = len_err_q;
    assign state_dbg = state_q;

`ifdef PFB_ARB_STALL_MON_EN
    localparam int SW = $clog2(STALL_LIMIT + 1);

    logic [SW-1:0] stall_cnt_q, stall_cnt_d;

    // Cycles with the granted source idle hold the count; only a beat or
    // dropping the grant restarts it.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q != ARB_GRANT || beat) begin
            stall_cnt_d = '0;
        end else if (out_valid && !bus.m_tready && stall_cnt_q != SW'(STALL_LIMIT)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign block = (stall_cnt_q == SW'(STALL_LIMIT));
`else
    assign block = 1'b0;
`endif

endmodule

// File: tb/tb_pfb_output_arbiter.sv
// Self-checking bench for pfb_output_arbiter: packet-level round-robin model,
// beat scoreboard, directed timing/boundary scenarios and randomized traffic.
module tb_pfb_output_arbiter;
    import pfb_arb_pkg::*;

    localparam int N_CH        = 4;
    localparam int DW          = 32;
    localparam int MAX_BEATS   = 1024;
    localparam int STALL_LIMIT = 4096;
    localparam int TW          = $clog2(N_CH);
    localparam int W           = TW + 1 + DW;
`ifdef PFB_ARB_STALL_MON_EN
    localparam logic BLK_EXP = 1'b1;
`else
    localparam logic BLK_EXP = 1'b0;
`endif

    logic            clock = 1'b0;
    logic            reset;
    logic [N_CH-1:0] chan_en;
    logic            len_err;
    logic            block;
    arb_state_t      state_dbg;

    pfb_output_arbiter_if #(.N_CH(N_CH), .DW(DW)) bus ();

    pfb_output_arbiter #(
        .N_CH(N_CH), .DW(DW), .MAX_BEATS(MAX_BEATS), .STALL_LIMIT(STALL_LIMIT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .chan_en   (chan_en),
        .len_err   (len_err),
        .block     (block),
        .state_dbg (state_dbg)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Channel sources: each entry is {tlast, tdata}; packet lengths feed the model.
    logic [DW:0]   src_q[N_CH][$];
    int            pkt_len[N_CH][$];
    logic [W-1:0]  exp_q[$];
    int            beat_cyc[$];
    int            dest_seen[$];
    int            pkt_dest[$];
    int            model_last;
    int            cyc;
    int            beats;
    bit            sb_en;
    bit            rdy_rand;
    logic          mready;
    logic [N_CH-1:0] rdy_seen;
    logic          mvalid_s, blk_s, lerr_s;
    arb_state_t    state_s;

    task automatic clear_env();
        for (int c = 0; c < N_CH; c++) begin
            src_q[c].delete();
            pkt_len[c].delete();
        end
        exp_q.delete();
        beat_cyc.delete();
        dest_seen.delete();
        pkt_dest.delete();
        model_last = N_CH - 1;
        cyc = 0;
        beats = 0;
        rdy_seen = '0;
        sb_en = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.s_tdata  = '0;
        bus.s_tvalid = '0;
        bus.s_tlast  = '0;
        bus.m_tready = 1'b0;
        mready   = 1'b1;
        rdy_rand = 1'b0;
        chan_en  = '1;
        clear_env();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic load_packet(input int ch, input int len);
        logic [DW:0] b;
        for (int i = 0; i < len; i++) begin
            b = {(i == len - 1) ? 1'b1 : 1'b0, DW'($urandom)};
            src_q[ch].push_back(b);
        end
        pkt_len[ch].push_back(len);
    endtask

    // Reference: whole packets in round-robin order among enabled channels
    // that still have packets queued (sources hold tvalid continuously).
    task automatic build_exp();
        int  off[N_CH];
        bit  found;
        int  c, len;
        logic [DW:0]  b;
        logic [W-1:0] e;
        for (int k = 0; k < N_CH; k++) off[k] = 0;
        do begin
            found = 1'b0;
            for (int k = 1; k <= N_CH; k++) begin
                c = (model_last + k) % N_CH;
                if (!found && chan_en[c] && pkt_len[c].size() > 0) begin
                    found = 1'b1;
                    len = pkt_len[c].pop_front();
                    for (int i = 0; i < len; i++) begin
                        b = src_q[c][off[c] + i];
                        e = {TW'(c), b};
                        exp_q.push_back(e);
                    end
                    off[c] += len;
                    model_last = c;
                end
            end
        end while (found);
    endtask

    task automatic drive_inputs();
        logic [DW:0] b;
        for (int c = 0; c < N_CH; c++) begin
            if (src_q[c].size() > 0) begin
                b = src_q[c][0];
                bus.s_tvalid[c]            = 1'b1;
                bus.s_tlast[c]             = b[DW];
                bus.s_tdata[c*DW +: DW]    = b[DW-1:0];
            end else begin
                bus.s_tvalid[c]            = 1'b0;
                bus.s_tlast[c]             = 1'b0;
                bus.s_tdata[c*DW +: DW]    = '0;
            end
        end
        bus.m_tready = rdy_rand ? ($urandom_range(0, 3) != 0) : mready;
    endtask

    task automatic sample();
        logic [W-1:0]    got, exp;
        logic [N_CH-1:0] rdy_exp;
        mvalid_s = bus.m_tvalid;
        blk_s    = block;
        lerr_s   = len_err;
        state_s  = state_dbg;
        rdy_seen |= bus.s_tready;
        rdy_exp = (bus.m_tvalid && bus.m_tready) ? N_CH'(1) << bus.m_tdest : '0;
        checks++;
        if (bus.s_tready !== rdy_exp) begin
            errors++;
            $display("FAIL s_tready cyc=%0d got=%b want=%b", cyc, bus.s_tready, rdy_exp);
        end
        if (bus.m_tvalid && bus.m_tready) begin
            beats++;
            beat_cyc.push_back(cyc);
            dest_seen.push_back(int'(bus.m_tdest));
            if (bus.m_tlast) pkt_dest.push_back(int'(bus.m_tdest));
            if (sb_en) begin
                got = {bus.m_tdest, bus.m_tlast, bus.m_tdata};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat cyc=%0d got=%h want=none", cyc, got);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL beat cyc=%0d got=%h want=%h", cyc, got, exp);
                    end
                end
            end
        end
        for (int c = 0; c < N_CH; c++)
            if (bus.s_tvalid[c] && bus.s_tready[c]) void'(src_q[c].pop_front());
        cyc++;
    endtask

    task automatic step();
        drive_inputs();
        @(negedge clock);
        sample();
        @(posedge clock);
        #1;
    endtask

    task automatic run_until_empty(input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL timeout pending=%0d want=0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clock);
        checks += 8;
        if (bus.m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_m_tvalid got=%b want=0", bus.m_tvalid); end
        if (bus.m_tlast  !== 1'b0) begin errors++; $display("FAIL rst_m_tlast got=%b want=0", bus.m_tlast); end
        if (bus.s_tready !== '0)   begin errors++; $display("FAIL rst_s_tready got=%b want=0", bus.s_tready); end
        if (bus.m_tdest  !== '0)   begin errors++; $display("FAIL rst_m_tdest got=%0d want=0", bus.m_tdest); end
        if (bus.m_tdata  !== '0)   begin errors++; $display("FAIL rst_m_tdata got=%h want=0", bus.m_tdata); end
        if (len_err      !== 1'b0) begin errors++; $display("FAIL rst_len_err got=%b want=0", len_err); end
        if (block        !== 1'b0) begin errors++; $display("FAIL rst_block got=%b want=0", block); end
        if (state_dbg    !== ARB_IDLE) begin errors++; $display("FAIL rst_state got=%0d want=IDLE", state_dbg); end
        @(posedge clock);
        #1;
    endtask

    task automatic test_two_channels();
        int t;
        int exp_cyc[$];
        do_reset();
        load_packet(0, 4);
        load_packet(2, 4);
        build_exp();
        run_until_empty(100);
        t = 1;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 4; i++) exp_cyc.push_back(t + i);
            t += 5;
        end
        checks++;
        if (beat_cyc.size() != 8) begin
            errors++;
            $display("FAIL two_ch_beats got=%0d want=8", beat_cyc.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks += 2;
                if (beat_cyc[i] != exp_cyc[i]) begin
                    errors++;
                    $display("FAIL two_ch_cycle beat=%0d got=%0d want=%0d", i, beat_cyc[i], exp_cyc[i]);
                end
                if (dest_seen[i] != ((i < 4) ? 0 : 2)) begin
                    errors++;
                    $display("FAIL two_ch_dest beat=%0d got=%0d want=%0d", i, dest_seen[i], (i < 4) ? 0 : 2);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int p = 0; p < 3; p++)
            for (int c = 0; c < N_CH; c++) load_packet(c, $urandom_range(1, 8));
        rdy_rand = 1'b1;
        build_exp();
        run_until_empty(1000);
        checks++;
        if (pkt_dest.size() != 12) begin
            errors++;
            $display("FAIL rr_pkts got=%0d want=12", pkt_dest.size());
        end else begin
            for (int k = 0; k < 12; k++) begin
                checks++;
                if (pkt_dest[k] != k % N_CH) begin
                    errors++;
                    $display("FAIL rr_order pkt=%0d got=%0d want=%0d", k, pkt_dest[k], k % N_CH);
                end
            end
        end
    endtask

    task automatic test_chan_en();
        int n2 = 0;
        do_reset();
        chan_en = 4'b1011;
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < N_CH; c++) load_packet(c, $urandom_range(1, 6));
        rdy_rand = 1'b1;
        build_exp();
        run_until_empty(1000);
        repeat (5) step();
        foreach (pkt_dest[k]) if (pkt_dest[k] == 2) n2++;
        checks += 3;
        if (rdy_seen[2] !== 1'b0) begin errors++; $display("FAIL en_ready2 got=%b want=0", rdy_seen[2]); end
        if (n2 != 0) begin errors++; $display("FAIL en_grant2 got=%0d want=0", n2); end
        if (pkt_dest.size() != 6) begin errors++; $display("FAIL en_pkts got=%0d want=6", pkt_dest.size()); end
    endtask

    task automatic test_stall();
        do_reset();
        load_packet(0, 8);
        build_exp();
        mready = 1'b1;
        repeat (3) step();
        mready = 1'b0;
        for (int i = 1; i <= STALL_LIMIT; i++) step();
        checks++;
        if (blk_s !== 1'b0) begin errors++; $display("FAIL block_early got=%b want=0", blk_s); end
        step();
        checks++;
        if (blk_s !== BLK_EXP) begin errors++; $display("FAIL block_set got=%b want=%b", blk_s, BLK_EXP); end
        step();
        checks++;
        if (blk_s !== BLK_EXP) begin errors++; $display("FAIL block_hold got=%b want=%b", blk_s, BLK_EXP); end
        mready = 1'b1;
        step();
        checks++;
        if (blk_s !== BLK_EXP) begin errors++; $display("FAIL block_beat got=%b want=%b", blk_s, BLK_EXP); end
        step();
        checks++;
        if (blk_s !== 1'b0) begin errors++; $display("FAIL block_clear got=%b want=0", blk_s); end
        run_until_empty(50);
    endtask

    task automatic test_len_err();
        int b0;
        int n;
        do_reset();
        load_packet(1, MAX_BEATS);
        build_exp();
        run_until_empty(MAX_BEATS + 20);
        checks++;
        if (len_err !== 1'b0) begin errors++; $display("FAIL len_legal got=%b want=0", len_err); end
        load_packet(1, MAX_BEATS + 1);
        build_exp();
        b0 = beats;
        n = 0;
        while (beats < b0 + MAX_BEATS && n < MAX_BEATS + 20) begin
            step();
            n++;
        end
        checks++;
        if (lerr_s !== 1'b0) begin errors++; $display("FAIL len_at_1024 got=%b want=0", lerr_s); end
        step();
        checks++;
        if (lerr_s !== 1'b1) begin errors++; $display("FAIL len_after_1024 got=%b want=1", lerr_s); end
        run_until_empty(20);
        load_packet(3, 3);
        build_exp();
        run_until_empty(20);
        checks++;
        if (len_err !== 1'b1) begin errors++; $display("FAIL len_sticky got=%b want=1", len_err); end
        do_reset();
        checks++;
        if (len_err !== 1'b0) begin errors++; $display("FAIL len_reset got=%b want=0", len_err); end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        load_packet(1, 4);
        sb_en = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        clear_env();
        for (int c = 0; c < N_CH; c++) load_packet(c, 3);
        build_exp();
        step();
        checks += 2;
        if (mvalid_s !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b want=0", mvalid_s); end
        if (state_s !== ARB_IDLE) begin errors++; $display("FAIL rstmid_state got=%0d want=IDLE", state_s); end
        run_until_empty(100);
        checks++;
        if (pkt_dest.size() == 0 || pkt_dest[0] != 0) begin
            errors++;
            $display("FAIL rstmid_first got=%0d want=0", (pkt_dest.size() == 0) ? -1 : pkt_dest[0]);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            do_reset();
            chan_en = N_CH'($urandom_range(1, (1 << N_CH) - 1));
            for (int c = 0; c < N_CH; c++)
                for (int p = $urandom_range(0, 3); p > 0; p--) load_packet(c, $urandom_range(1, 12));
            rdy_rand = 1'b1;
            build_exp();
            run_until_empty(2000);
        end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_two_channels();
        test_round_robin();
        test_chan_en();
        test_stall();
        test_len_err();
        test_reset_mid_packet();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pfb_output_arbiter.md
# pfb_output_arbiter

Packet-level round-robin arbiter that shares the single AXI-Stream output of the multichannel PFB decimator between the four per-channel output streams of the write-outputs stage. It sits between the decimator's channel streams and the downstream packetiser/DMA. It grants one channel per packet (delimited by `tlast`), and supports per-channel enable. It flags length errors and, optionally, sustained output stalls, mirroring what the cosim deadlock monitors report for these four AXIS ports.

## Interface
Parameters:
- `N_CH`, 4: number of input channel streams (power of two, 2..16).
- `DW`, 32: data width per stream.
- `MAX_BEATS`, 1024: maximum legal beats per packet.
- `STALL_LIMIT`, 4096: consecutive stalled cycles before `block` asserts.

Ports:
- `clock` input 1: clock; all logic rising-edge.
- `reset` input 1: reset, synchronous, active-high.
- `s_tdata` input `N_CH*DW`: channel data; channel i occupies `[i*DW +: DW]`.
- `s_tvalid` input `N_CH`: per-channel valid.
- `s_tlast` input `N_CH`: per-channel end of packet.
- `s_tready` output `N_CH`: per-channel ready.
- `m_tdata` output `DW`: merged data.
- `m_tvalid` output 1: merged valid.
- `m_tlast` output 1: merged end of packet.
- `m_tdest` output `$clog2(N_CH)`: channel index of the current packet.
- `m_tready` input 1: downstream ready.
- `chan_en` input `N_CH`: arbitration enable per channel.
- `len_err` output 1: sticky; a packet exceeded `MAX_BEATS`.
- `block` output 1: output stalled for `STALL_LIMIT` cycles.

## Operation
- FSM states:
  - IDLE: no grant.
  - GRANT: `grant` register selects the channel.
- IDLE to GRANT:
  - The request vector is `s_tvalid & chan_en`.
  - If it is non-zero, the arbiter picks the first set bit searching upward from `last+1` mod `N_CH`, registers `grant`, and moves to GRANT.
  - All `s_tready` are 0 in IDLE.
- In GRANT, the datapath is combinational:
  - `m_tdata`, `m_tvalid` and `m_tlast` mirror channel `grant`.
  - `s_tready[grant] = m_tready`; all other `s_tready` are 0.
  - `m_tdest = grant`.
- GRANT to IDLE: on a beat (`m_tvalid & m_tready`) with `m_tlast`. `last <= grant`.
- Deasserting `chan_en[grant]` mid-packet does not abort the packet; it only affects the next arbitration.
- Beat counter:
  - 11 bits (`$clog2(MAX_BEATS)+1`). It clears on entry to GRANT and increments per beat.
  - A beat with count == `MAX_BEATS` and no `tlast` sets `len_err`. The packet continues.
  - `len_err` clears only on reset.
- Stall counter (macro-gated):
  - Increments while GRANT & `m_tvalid` & !`m_tready`, saturating at `STALL_LIMIT`.
  - Clears on any beat or on leaving GRANT.
  - `block` is 1 while count == `STALL_LIMIT`.

## Timing
- Reset values:
  - FSM = IDLE, `last = N_CH-1` (so channel 0 wins first).
  - `m_tvalid`, `m_tlast`, `s_tready`, `len_err` and `block` are 0; `m_tdest` = 0; `m_tdata` = 0.
- Latency: a request in IDLE at cycle t gives `m_tvalid` at t+1. There is zero latency per beat within a packet.
- Inter-packet gap: exactly one IDLE cycle after each `tlast` beat.
- Throughput: one beat per cycle within a packet.
- Reset mid-packet: the grant is dropped immediately at the next edge; the partial packet is truncated; the upstream is responsible for resynchronising.
- Simultaneous requests: strict round-robin, so no channel waits more than `N_CH-1` packets.
- AXIS rule: once `m_tvalid` is high, data is held until the beat. This follows from the source obeying AXIS and grant being stable in GRANT.

## Configuration
- `PFB_ARB_STALL_MON_EN`:
  - Defined: the stall counter and `block` logic are present as described.
  - Undefined: `block` is tied to 0, and no stall counter is synthesised.

## Structure
- Shared package `pfb_arb_pkg`:
  - FSM state enum (`ARB_IDLE`, `ARB_GRANT`).
  - Default `N_CH`/`DW` constants.
  - A function `rr_pick(req, last)` that returns the next index.
- Sub-module `pfb_rr_arbiter`: combinational round-robin picker (req, last to idx, any). It is reusable by other multichannel PFB stages.

## Test plan
- After reset, channels 0 and 2 both valid with 4-beat packets: grants go 0 then 2, `m_tdest` = 0,0,0,0 then 2,2,2,2, and there is 1 idle cycle between packets.
- All 4 channels continuously valid, 3 packets each: grant order is 0,1,2,3,0,1,2,3,0,1,2,3 and no packet is interleaved.
- `chan_en = 4'b1011` with all channels valid: channel 2 is never granted and `s_tready[2]` stays 0.
- `m_tready` held low 4096 cycles mid-packet (macro defined): `block` = 1 from stalled cycle 4096 and clears the cycle after the next beat. With the macro undefined, `block` stays 0.
- 1025-beat packet without `tlast` on beat 1024: `len_err` = 1 after beat 1024 and stays 1 until reset.
- Reset asserted on beat 2 of a packet on channel 1: the next cycle has `m_tvalid` = 0 and state IDLE. The next arbitration with all channels valid grants channel 0.
